// File: rtl/cpu_sequencer.sv
// Instruction-phase sequencer: FETCH -> DECODE -> EXEC -> [RDMEM] -> FETCH, with
// per-phase memory wait counting, halt at instruction boundaries and a retired-instruction counter.
module cpu_sequencer #(
  parameter int RD_WAIT    = 0,
  parameter int FETCH_WAIT = 0,
  parameter int SKIP_RDMEM = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             insn_rd,
  input  logic             mem_rdy,
  input  logic             halt,
  output logic             phase_decode,
  output logic             phase_exec,
  output logic             phase_rdmem,
  output logic             phase_fetch,
  output logic             phase_half,
  output logic             phase_adv,
  output logic             halted,
  output logic [CNT_W-1:0] insn_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_RDMEM,
    S_HALT
  } state_e;

  localparam logic [3:0] RD_WAIT_L    = 4'(RD_WAIT);
  localparam logic [3:0] FETCH_WAIT_L = 4'(FETCH_WAIT);
  localparam logic       SKIP_L       = (SKIP_RDMEM != 0);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_done;

  // A memory phase may only finish once its fixed wait has fully elapsed.
  assign mem_done = (wait_q == 4'd0) & mem_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= FETCH_WAIT_L;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = (wait_q != 4'd0) ? wait_q - 4'd1 : wait_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (mem_done) begin
          cnt_d   = cnt_q + CNT_W'(1'b1);
          state_d = halt ? S_HALT : S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (insn_rd | ~SKIP_L) begin
          state_d = S_RDMEM;
          wait_d  = RD_WAIT_L;
        end else begin
          state_d = S_FETCH;
          wait_d  = FETCH_WAIT_L;
        end
      end
      S_RDMEM: begin
        if (mem_done) begin
          state_d = S_FETCH;
          wait_d  = FETCH_WAIT_L;
        end
      end
      S_HALT: begin
        if (!halt) begin
          state_d = S_FETCH;
          wait_d  = FETCH_WAIT_L;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    phase_fetch  = (state_q == S_FETCH);
    phase_decode = (state_q == S_DECODE);
    phase_exec   = (state_q == S_EXEC);
    phase_rdmem  = (state_q == S_RDMEM);
    halted       = (state_q == S_HALT);
    phase_half   = phase_decode | phase_exec;
    phase_adv    = 1'b0;
    case (state_q)
      S_FETCH, S_RDMEM:  phase_adv = mem_done;
      S_DECODE, S_EXEC:  phase_adv = 1'b1;
      default:           phase_adv = 1'b0;
    endcase
    insn_count   = cnt_q;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: four parameterisations share one stimulus bus,
// each scenario resets all of them and checks the instance it targets.
module tb_cpu_sequencer;

  localparam logic [4:0] F = 5'b10000;
  localparam logic [4:0] D = 5'b01000;
  localparam logic [4:0] E = 5'b00100;
  localparam logic [4:0] R = 5'b00010;
  localparam logic [4:0] H = 5'b00001;

  logic clk, rst, insn_rd, mem_rdy, halt;
  logic pf[4], pd[4], pe[4], pr[4], pa[4], hf[4], hl[4];
  logic [15:0] c0, c1, c3;
  logic [1:0]  c2;
  int nvec = 0;
  int nerr = 0;

  cpu_sequencer u0 (
    .clk(clk), .rst(rst), .insn_rd(insn_rd), .mem_rdy(mem_rdy), .halt(halt),
    .phase_decode(pd[0]), .phase_exec(pe[0]), .phase_rdmem(pr[0]), .phase_fetch(pf[0]),
    .phase_half(hf[0]), .phase_adv(pa[0]), .halted(hl[0]), .insn_count(c0)
  );

  cpu_sequencer #(.FETCH_WAIT(3)) u1 (
    .clk(clk), .rst(rst), .insn_rd(insn_rd), .mem_rdy(mem_rdy), .halt(halt),
    .phase_decode(pd[1]), .phase_exec(pe[1]), .phase_rdmem(pr[1]), .phase_fetch(pf[1]),
    .phase_half(hf[1]), .phase_adv(pa[1]), .halted(hl[1]), .insn_count(c1)
  );

  cpu_sequencer #(.CNT_W(2), .SKIP_RDMEM(0)) u2 (
    .clk(clk), .rst(rst), .insn_rd(insn_rd), .mem_rdy(mem_rdy), .halt(halt),
    .phase_decode(pd[2]), .phase_exec(pe[2]), .phase_rdmem(pr[2]), .phase_fetch(pf[2]),
    .phase_half(hf[2]), .phase_adv(pa[2]), .halted(hl[2]), .insn_count(c2)
  );

  cpu_sequencer #(.RD_WAIT(2)) u3 (
    .clk(clk), .rst(rst), .insn_rd(insn_rd), .mem_rdy(mem_rdy), .halt(halt),
    .phase_decode(pd[3]), .phase_exec(pe[3]), .phase_rdmem(pr[3]), .phase_fetch(pf[3]),
    .phase_half(hf[3]), .phase_adv(pa[3]), .halted(hl[3]), .insn_count(c3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs_ph(input int u);
    return {pf[u], pd[u], pe[u], pr[u], hl[u]};
  endfunction

  function automatic logic [31:0] obs_cnt(input int u);
    case (u)
      0:       return {16'd0, c0};
      1:       return {16'd0, c1};
      2:       return {30'd0, c2};
      default: return {16'd0, c3};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then move to the next cycle.
  task automatic vec(input int u, input logic ins, input logic rdy, input logic hlt,
                     input logic [4:0] eph, input logic eadv, input int ecnt);
    insn_rd = ins;
    mem_rdy = rdy;
    halt    = hlt;
    #1;
    check($sformatf("u%0d t%0t phase", u, $time), 32'(obs_ph(u)), 32'(eph));
    check($sformatf("u%0d t%0t adv", u, $time), 32'(pa[u]), 32'(eadv));
    check($sformatf("u%0d t%0t half", u, $time), 32'(hf[u]), 32'((eph == D) || (eph == E)));
    check($sformatf("u%0d t%0t count", u, $time), obs_cnt(u), 32'(ecnt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    insn_rd = 1'b0;
    mem_rdy = 1'b1;
    halt    = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b1;
    insn_rd = 1'b0;
    mem_rdy = 1'b1;
    halt    = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst u0 phase", 32'(obs_ph(0)), 32'(F));
    check("rst u0 adv", 32'(pa[0]), 32'd1);
    check("rst u0 count", obs_cnt(0), 32'd0);
    check("rst u1 adv", 32'(pa[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst hold u0 phase", 32'(obs_ph(0)), 32'(F));
    check("rst hold u0 count", obs_cnt(0), 32'd0);

    // Defaults: alternating insn_rd, then halt raised in EXEC and later dropped.
    rst = 1'b1;
    vec(0, 0, 1, 0, F, 1, 0);
    vec(0, 0, 1, 0, D, 1, 1);
    vec(0, 0, 1, 0, E, 1, 1);
    vec(0, 1, 1, 0, F, 1, 1);
    vec(0, 1, 1, 0, D, 1, 2);
    vec(0, 1, 1, 0, E, 1, 2);
    vec(0, 0, 1, 0, R, 1, 2);
    vec(0, 0, 1, 0, F, 1, 2);
    vec(0, 0, 0, 0, D, 1, 3);
    vec(0, 0, 1, 1, E, 1, 3);
    vec(0, 0, 1, 1, F, 1, 3);
    vec(0, 0, 1, 1, H, 0, 4);
    vec(0, 0, 1, 1, H, 0, 4);
    vec(0, 0, 1, 0, H, 0, 4);
    vec(0, 0, 1, 0, F, 1, 4);
    vec(0, 0, 1, 0, D, 1, 5);

    // FETCH_WAIT=3: four-cycle fetch, then a fetch stretched by mem_rdy to six cycles.
    do_reset();
    vec(1, 0, 1, 0, F, 0, 0);
    vec(1, 0, 1, 0, F, 0, 0);
    vec(1, 0, 1, 0, F, 0, 0);
    vec(1, 0, 1, 0, F, 1, 0);
    vec(1, 0, 1, 0, D, 1, 1);
    vec(1, 0, 1, 0, E, 1, 1);
    for (int i = 0; i < 5; i++) vec(1, 0, 0, 0, F, 0, 1);
    vec(1, 0, 1, 0, F, 1, 1);
    vec(1, 0, 1, 0, D, 1, 2);

    // CNT_W=2, RDMEM always entered: fixed F,D,E,R with a wrapping count.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      vec(2, 0, 1, 0, F, 1, k % 4);
      vec(2, 0, 1, 0, D, 1, (k + 1) % 4);
      vec(2, 0, 1, 0, E, 1, (k + 1) % 4);
      vec(2, 0, 1, 0, R, 1, (k + 1) % 4);
    end

    // RD_WAIT=2: reset dropped in the 2nd RDMEM cycle, then a clean restart.
    do_reset();
    vec(3, 1, 1, 0, F, 1, 0);
    vec(3, 1, 1, 0, D, 1, 1);
    vec(3, 1, 1, 0, E, 1, 1);
    vec(3, 1, 1, 0, R, 0, 1);
    #1;
    check("u3 rdmem2 phase", 32'(obs_ph(3)), 32'(R));
    check("u3 rdmem2 adv", 32'(pa[3]), 32'd0);
    rst = 1'b0;
    #1;
    check("u3 async rst phase", 32'(obs_ph(3)), 32'(F));
    check("u3 async rst count", obs_cnt(3), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("u3 rst held phase", 32'(obs_ph(3)), 32'(F));
    rst = 1'b1;
    vec(3, 1, 1, 0, F, 1, 0);
    vec(3, 1, 1, 0, D, 1, 1);
    vec(3, 1, 1, 0, E, 1, 1);
    vec(3, 0, 1, 0, R, 0, 1);
    vec(3, 0, 1, 0, R, 0, 1);
    vec(3, 0, 1, 0, R, 1, 1);
    vec(3, 0, 1, 0, F, 1, 1);
    vec(3, 0, 1, 0, D, 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
